text_cursor_ctrl: RTL

// - Sequences all writes into the character RAM behind the VGA text renderer. Accepts one ASCII

---
 rtl/text_cursor_ctrl_pkg.sv | 23 ++
 rtl/text_cursor_ctrl_cell_addr_calc.sv | 17 +
 rtl/text_cursor_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/text_cursor_ctrl_pkg.sv
// Shared constants, state encoding and character classification for the text cursor controller.
package text_cursor_ctrl_pkg;

    localparam int COLS_DEF = 80;
    localparam int ROWS_DEF = 30;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_TILDE = 8'h7E;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_CLEAR = 2'd2
    } state_e;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= ASCII_SPACE) && (c <= ASCII_TILDE);
    endfunction

endpackage

// File: rtl/text_cursor_ctrl_cell_addr_calc.sv
// Combinational cell address y*COLS + x, shared with the renderer so both sides agree.
module cell_addr_calc #(
    parameter int COLS   = 80,
    parameter int ADDR_W = 12
) (
    input  logic [6:0]        x,
    input  logic [4:0]        y,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] row_base_s;

    // The row product is deliberately truncated to the address width.
    assign row_base_s = ADDR_W'(y) * ADDR_W'(COLS);
    assign addr       = row_base_s + ADDR_W'(x);

endmodule

// File: rtl/text_cursor_ctrl.sv
// Character RAM write sequencer: cursor tracking, CR/LF/BS handling and full-screen clear.
// Optional cursor blinking is enabled by defining CURSOR_BLINK_EN.
module text_cursor_ctrl
    import text_cursor_ctrl_pkg::*;
#(
    parameter int COLS         = COLS_DEF,
    parameter int ROWS         = ROWS_DEF,
    parameter int ADDR_W       = 12,
    parameter int BLINK_CYCLES = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              char_valid,
    input  logic [7:0]        char_data,
    output logic              char_ready,
    input  logic              clear_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [7:0]        ram_wdata,
    output logic [6:0]        cursor_x,
    output logic [4:0]        cursor_y,
    output logic              cursor_on,
    output logic              busy
);

    if ((2 ** ADDR_W) < (COLS * ROWS)) begin : g_addr_w_check
        $error("ADDR_W too small for COLS*ROWS cells");
    end
    if (BLINK_CYCLES < 2) begin : g_blink_check
        $error("BLINK_CYCLES must be at least 2");
    end

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);

    state_e            state_q, state_d;
    logic [6:0]        x_q, x_d;
    logic [4:0]        y_q, y_d;
    logic [7:0]        byte_q, byte_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    logic              hs_s, clr_start_s, at_origin_s;
    logic [6:0]        bs_x_s, addr_x_s;
    logic [4:0]        bs_y_s, addr_y_s, next_y_s;
    logic [ADDR_W-1:0] cell_addr_s;

    assign char_ready  = reset & (state_q == S_IDLE) & ~clear_req;
    assign hs_s        = char_valid & char_ready;
    assign clr_start_s = (state_q == S_IDLE) & clear_req;
    assign busy        = (state_q != S_IDLE);
    assign ram_we      = we_q;
    assign ram_waddr   = waddr_q;
    assign ram_wdata   = wdata_q;
    assign cursor_x    = x_q;
    assign cursor_y    = y_q;

    assign at_origin_s = (x_q == 7'd0) && (y_q == 5'd0);
    assign next_y_s    = (y_q == 5'(ROWS - 1)) ? 5'd0 : y_q + 5'd1;

    // Cell one step behind the cursor, used by backspace.
    always_comb begin
        if (x_q == 7'd0) begin
            bs_x_s = 7'(COLS - 1);
            bs_y_s = y_q - 5'd1;
        end else begin
            bs_x_s = x_q - 7'd1;
            bs_y_s = y_q;
        end
    end

    assign addr_x_s = (byte_q == ASCII_BS) ? bs_x_s : x_q;
    assign addr_y_s = (byte_q == ASCII_BS) ? bs_y_s : y_q;

    cell_addr_calc #(.COLS(COLS), .ADDR_W(ADDR_W)) u_addr (
        .x    (addr_x_s),
        .y    (addr_y_s),
        .addr (cell_addr_s)
    );

    // Next-state and output computation for the IDLE/WRITE/CLEAR sequencer.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        byte_d    = byte_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (clear_req) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = '0;
                end else if (hs_s) begin
                    byte_d  = char_data;
                    state_d = S_WRITE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
                if (is_printable(byte_q)) begin
                    we_d    = 1'b1;
                    waddr_d = cell_addr_s;
                    wdata_d = byte_q;
                    if (x_q == 7'(COLS - 1)) begin
                        x_d = 7'd0;
                        y_d = next_y_s;
                    end else begin
                        x_d = x_q + 7'd1;
                    end
                end else if ((byte_q == ASCII_CR) || (byte_q == ASCII_LF)) begin
                    x_d = 7'd0;
                    y_d = next_y_s;
                end else if ((byte_q == ASCII_BS) && !at_origin_s) begin
                    we_d    = 1'b1;
                    waddr_d = cell_addr_s;
                    wdata_d = ASCII_SPACE;
                    x_d     = bs_x_s;
                    y_d     = bs_y_s;
                end else begin
                    x_d = x_q;
                end
            end
            S_CLEAR: begin
                we_d    = 1'b1;
                waddr_d = clr_cnt_q;
                wdata_d = ASCII_SPACE;
                if (clr_cnt_q == LAST_CELL) begin
                    state_d = S_IDLE;
                    x_d     = 7'd0;
                    y_d     = 5'd0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            x_q       <= 7'd0;
            y_q       <= 5'd0;
            byte_q    <= 8'd0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= 8'd0;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            byte_q    <= byte_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

`ifdef CURSOR_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_CYCLES);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               cursor_on_q, cursor_on_d;

    // Typing or clearing restarts the blink phase with the cursor visible.
    always_comb begin
        if (hs_s || clr_start_s) begin
            blink_cnt_d = '0;
            cursor_on_d = 1'b1;
        end else if (blink_cnt_q == BLINK_W'(BLINK_CYCLES - 1)) begin
            blink_cnt_d = '0;
            cursor_on_d = ~cursor_on_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
            cursor_on_d = cursor_on_q;
        end
    end

    // Blink counter and visibility flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt_q <= '0;
            cursor_on_q <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            cursor_on_q <= cursor_on_d;
        end
    end

    assign cursor_on = cursor_on_q;
`else
    assign cursor_on = 1'b1;
`endif

endmodule
